// File: rtl/srf05_ranger.sv
// rtl/srf05_ranger.sv - SRF05 ultrasonic ranger: trigger generation, echo width timing, distance publish
module srf05_ranger #(
  parameter int unsigned CLKS_PER_US  = 100,
  parameter int unsigned TRIG_US      = 10,
  parameter int unsigned ECHO_WAIT_US = 1000,
  parameter int unsigned TIMEOUT_US   = 30000,
  parameter int unsigned CYCLE_US     = 50000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        echo,
  output logic        trigger,
  output logic [14:0] distance,
  output logic        new_data,
  output logic        error_no_echo,
  output logic        error_timeout,
  output logic        busy
);

  localparam int unsigned PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam int unsigned CW = $clog2(CYCLE_US + 1);
  localparam logic [PW-1:0] PRESC_LAST  = PW'(CLKS_PER_US - 1);
  localparam logic [PW-1:0] PRESC_HALF  = PW'(CLKS_PER_US / 2);
  localparam logic          ROUND_EN    = (CLKS_PER_US > 1);
  localparam logic [14:0]   TRIG_LAST   = 15'(TRIG_US - 1);
  localparam logic [14:0]   WAIT_LAST   = 15'(ECHO_WAIT_US - 1);
  localparam logic [14:0]   TIMEOUT_CNT = 15'(TIMEOUT_US);
  localparam logic [CW-1:0] CYCLE_CNT   = CW'(CYCLE_US);
  localparam logic [CW-1:0] CYCLE_LAST  = CW'(CYCLE_US - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_ECHO,
    ST_MEASURE,
    ST_HOLDOFF
  } state_t;

  state_t        state_q;
  logic          trigger_q;
  logic [14:0]   distance_q;
  logic          new_data_q;
  logic          err_no_echo_q;
  logic          err_timeout_q;
  logic          busy_q;
  logic [PW-1:0] presc_q;
  logic [14:0]   us_cnt_q;
  logic [PW-1:0] cyc_presc_q;
  logic [CW-1:0] cyc_cnt_q;
  logic          echo_s1_q;
  logic          echo_s2_q;
  logic          echo_s3_q;

  logic          us_tick;
  logic          cyc_tick;
  logic          echo_rise;
  logic          echo_fall;
  logic          cyc_done;
  logic          round_up;
  logic [PW-1:0] presc_d;
  logic [14:0]   us_cnt_d;
  logic [PW-1:0] cyc_presc_d;
  logic [CW-1:0] cyc_cnt_d;
  logic [14:0]   width_us;

  assign us_tick   = (presc_q == PRESC_LAST);
  assign cyc_tick  = (cyc_presc_q == PRESC_LAST);
  assign echo_rise = echo_s2_q & ~echo_s3_q;
  assign echo_fall = ~echo_s2_q & echo_s3_q;

  assign presc_d     = us_tick ? '0 : presc_q + PW'(1);
  assign us_cnt_d    = us_cnt_q + 15'(us_tick);
  assign cyc_presc_d = cyc_tick ? '0 : cyc_presc_q + PW'(1);
  assign cyc_cnt_d   = (cyc_cnt_q == CYCLE_CNT) ? cyc_cnt_q : cyc_cnt_q + CW'(cyc_tick);

  // Looking one tick ahead keeps trigger rising edges exactly CYCLE_US apart.
  assign cyc_done = (cyc_cnt_q == CYCLE_CNT) || ((cyc_cnt_q == CYCLE_LAST) && cyc_tick);

  // The falling edge lands mid-microsecond; round the partial us to nearest.
  assign round_up = ROUND_EN && (presc_q >= PRESC_HALF);
  assign width_us = us_cnt_q + 15'(round_up);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      trigger_q     <= 1'b0;
      distance_q    <= '0;
      new_data_q    <= 1'b0;
      err_no_echo_q <= 1'b0;
      err_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      presc_q       <= '0;
      us_cnt_q      <= '0;
      cyc_presc_q   <= '0;
      cyc_cnt_q     <= '0;
      echo_s1_q     <= 1'b0;
      echo_s2_q     <= 1'b0;
      echo_s3_q     <= 1'b0;
    end else begin
      echo_s1_q   <= echo;
      echo_s2_q   <= echo_s1_q;
      echo_s3_q   <= echo_s2_q;
      new_data_q  <= 1'b0;
      presc_q     <= presc_d;
      us_cnt_q    <= us_cnt_d;
      cyc_presc_q <= cyc_presc_d;
      cyc_cnt_q   <= cyc_cnt_d;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_TRIG;
            trigger_q   <= 1'b1;
            busy_q      <= 1'b1;
            presc_q     <= '0;
            us_cnt_q    <= '0;
            cyc_presc_q <= '0;
            cyc_cnt_q   <= '0;
          end
        end

        ST_TRIG: begin
          if (us_tick && (us_cnt_q == TRIG_LAST)) begin
            state_q   <= ST_WAIT_ECHO;
            trigger_q <= 1'b0;
            presc_q   <= '0;
            us_cnt_q  <= '0;
          end
        end

        ST_WAIT_ECHO: begin
          if (echo_rise) begin
            state_q  <= ST_MEASURE;
            presc_q  <= '0;
            us_cnt_q <= '0;
          end else if (us_tick && (us_cnt_q == WAIT_LAST)) begin
            state_q       <= ST_HOLDOFF;
            err_no_echo_q <= 1'b1;
            presc_q       <= '0;
            us_cnt_q      <= '0;
          end
        end

        ST_MEASURE: begin
          if (echo_fall) begin
            state_q       <= ST_HOLDOFF;
            distance_q    <= width_us;
            new_data_q    <= 1'b1;
            err_no_echo_q <= 1'b0;
            err_timeout_q <= 1'b0;
            presc_q       <= '0;
            us_cnt_q      <= '0;
          end else if (us_cnt_q == TIMEOUT_CNT) begin
            state_q       <= ST_HOLDOFF;
            err_timeout_q <= 1'b1;
            presc_q       <= '0;
            us_cnt_q      <= '0;
          end
        end

        ST_HOLDOFF: begin
          if (cyc_done) begin
            presc_q  <= '0;
            us_cnt_q <= '0;
            if (start) begin
              state_q     <= ST_TRIG;
              trigger_q   <= 1'b1;
              cyc_presc_q <= '0;
              cyc_cnt_q   <= '0;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          trigger_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign trigger       = trigger_q;
  assign distance      = distance_q;
  assign new_data      = new_data_q;
  assign error_no_echo = err_no_echo_q;
  assign error_timeout = err_timeout_q;
  assign busy          = busy_q;

endmodule
